// File: rtl/prn_reclaim_if.sv
// Dispatch/complete/free bundle between rename and the PRN reclaim tracker.
// master = rename/dispatch side, slave = tracker.
interface prn_reclaim_if #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 16
);
  localparam int TAG_BITS = $clog2(DEPTH);

  logic                                        i_alloc_valid;
  logic                                        o_alloc_ready;
  logic [MAX_OPERANDS-1:0]                     i_alloc_old_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]       i_alloc_old_prn;
  logic [TAG_BITS-1:0]                         o_alloc_tag;
  logic                                        i_complete_valid;
  logic [TAG_BITS-1:0]                         i_complete_tag;
  logic [2*MAX_OPERANDS-1:0]                   o_free_valid;
  logic [2*MAX_OPERANDS-1:0][PRN_BITS-1:0]     o_free_prns;
  logic [1:0]                                  o_retire_count;
  logic                                        o_empty;

  modport master (
    output i_alloc_valid, i_alloc_old_valid, i_alloc_old_prn,
    output i_complete_valid, i_complete_tag,
    input  o_alloc_ready, o_alloc_tag, o_free_valid, o_free_prns,
    input  o_retire_count, o_empty
  );

  modport slave (
    input  i_alloc_valid, i_alloc_old_valid, i_alloc_old_prn,
    input  i_complete_valid, i_complete_tag,
    output o_alloc_ready, o_alloc_tag, o_free_valid, o_free_prns,
    output o_retire_count, o_empty
  );
endinterface

// File: rtl/prn_reclaim.sv
// In-order retirement tracker: holds displaced PRNs per instruction and
// returns them to rename when up to two oldest completed entries retire.
module prn_reclaim #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 16
) (
  input  logic            clk,
  input  logic            rst,
  prn_reclaim_if.slave    bus
);
  localparam int TAG_BITS = $clog2(DEPTH);
  localparam int NSLOT    = 2 * MAX_OPERANDS;

  logic [TAG_BITS-1:0]                   r_head;
  logic [TAG_BITS-1:0]                   r_tail;
  logic [TAG_BITS:0]                     r_count;
  logic [DEPTH-1:0]                      r_busy;
  logic [DEPTH-1:0]                      r_done;
  logic [MAX_OPERANDS-1:0]               r_old_valid [DEPTH];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_old_prn   [DEPTH];

  logic [NSLOT-1:0]                      r_free_valid;
  logic [NSLOT-1:0][PRN_BITS-1:0]        r_free_prns;
  logic [1:0]                            r_retire_count;

  logic                                  w_full;
  logic                                  w_accept;
  logic [TAG_BITS-1:0]                   w_head1;
  logic                                  w_r0;
  logic                                  w_r1;
  logic [1:0]                            w_retire_num;
  logic [NSLOT-1:0]                      w_free_valid_n;
  logic [NSLOT-1:0][PRN_BITS-1:0]        w_free_prns_n;

  assign w_full   = (r_count == (TAG_BITS+1)'(DEPTH));
  assign w_accept = bus.i_alloc_valid && !w_full;
  assign w_head1  = r_head + TAG_BITS'(1);

  // r1 depends on r0 so retirement can never skip the head entry.
  assign w_r0         = r_busy[r_head] && r_done[r_head];
  assign w_r1         = w_r0 && r_busy[w_head1] && r_done[w_head1];
  assign w_retire_num = {w_r1, w_r0 && !w_r1};

  always_comb begin
    w_free_valid_n = '0;
    w_free_prns_n  = '0;
    for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
      if (w_r0 && r_old_valid[r_head][k]) begin
        w_free_valid_n[k] = 1'b1;
        w_free_prns_n[k]  = r_old_prn[r_head][k];
      end
      if (w_r1 && r_old_valid[w_head1][k]) begin
        w_free_valid_n[MAX_OPERANDS+k] = 1'b1;
        w_free_prns_n[MAX_OPERANDS+k]  = r_old_prn[w_head1][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_done         <= '0;
      r_free_valid   <= '0;
      r_free_prns    <= '0;
      r_retire_count <= '0;
    end else begin
      r_free_valid   <= w_free_valid_n;
      r_free_prns    <= w_free_prns_n;
      r_retire_count <= w_retire_num;
      r_head         <= r_head + TAG_BITS'(w_retire_num);
      r_count        <= r_count + (TAG_BITS+1)'(w_accept)
                                - (TAG_BITS+1)'(w_retire_num);

      // Update order matters: retire clears override a same-cycle complete,
      // and the alloc write (on a distinct, idle slot) comes last.
      if (bus.i_complete_valid && r_busy[bus.i_complete_tag])
        r_done[bus.i_complete_tag] <= 1'b1;

      if (w_r0) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
      end
      if (w_r1) begin
        r_busy[w_head1] <= 1'b0;
        r_done[w_head1] <= 1'b0;
      end

      if (w_accept) begin
        r_busy[r_tail]      <= 1'b1;
        r_done[r_tail]      <= 1'b0;
        r_old_valid[r_tail] <= bus.i_alloc_old_valid;
        r_old_prn[r_tail]   <= bus.i_alloc_old_prn;
        r_tail              <= r_tail + TAG_BITS'(1);
      end
    end
  end

  assign bus.o_alloc_ready  = !w_full;
  assign bus.o_alloc_tag    = r_tail;
  assign bus.o_empty        = (r_count == '0);
  assign bus.o_free_valid   = r_free_valid;
  assign bus.o_free_prns    = r_free_prns;
  assign bus.o_retire_count = r_retire_count;
endmodule

// File: tb/tb_prn_reclaim.sv
// Bench for prn_reclaim: directed scenarios then random traffic, checked
// against an in-order queue model of in-flight instructions.
module tb_prn_reclaim;
  localparam int PB = 6;
  localparam int MO = 3;
  localparam int D  = 16;
  localparam int TB = $clog2(D);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prn_reclaim_if #(.PRN_BITS(PB), .MAX_OPERANDS(MO), .DEPTH(D)) bus ();
  prn_reclaim #(.PRN_BITS(PB), .MAX_OPERANDS(MO), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                      tag;
    bit                      done;
    logic [MO-1:0]           ov;
    logic [MO-1:0][PB-1:0]   prn;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;
  logic [2*MO-1:0]         exp_fv = '0;
  logic [2*MO-1:0][PB-1:0] exp_fp = '0;
  logic [1:0]              exp_rc = '0;

  int n_cmp = 0;
  int n_err = 0;

  bit                    v_rst = 1'b1;
  bit                    v_alloc = 1'b0;
  logic [MO-1:0]         v_ov = '0;
  logic [MO-1:0][PB-1:0] v_prn = '0;
  bit                    v_comp = 1'b0;
  int                    v_ctag = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int nret;
    bit acc;
    ent_t e;
    exp_fv = '0;
    exp_fp = '0;
    exp_rc = '0;
    if (v_rst) begin
      q.delete();
      next_tag = 0;
      return;
    end
    nret = 0;
    if (q.size() > 0 && q[0].done) begin
      nret = 1;
      if (q.size() > 1 && q[1].done) nret = 2;
    end
    for (int j = 0; j < nret; j++)
      for (int k = 0; k < MO; k++)
        if (q[j].ov[k]) begin
          exp_fv[j*MO+k] = 1'b1;
          exp_fp[j*MO+k] = q[j].prn[k];
        end
    exp_rc = 2'(nret);
    acc = v_alloc && (q.size() < D);
    if (v_comp)
      foreach (q[i]) if (q[i].tag == v_ctag) q[i].done = 1'b1;
    for (int j = 0; j < nret; j++) void'(q.pop_front());
    if (acc) begin
      e.tag  = next_tag;
      e.done = 1'b0;
      e.ov   = v_ov;
      e.prn  = v_prn;
      q.push_back(e);
      next_tag = (next_tag + 1) % D;
    end
  endtask

  task automatic cycle(input bit chk_comb);
    rst                   = v_rst;
    bus.i_alloc_valid     = v_alloc;
    bus.i_alloc_old_valid = v_ov;
    bus.i_alloc_old_prn   = v_prn;
    bus.i_complete_valid  = v_comp;
    bus.i_complete_tag    = TB'(v_ctag);
    #1;
    if (chk_comb) begin
      chk("alloc_ready", 64'(bus.o_alloc_ready), 64'(q.size() < D));
      chk("alloc_tag",   64'(bus.o_alloc_tag),   64'(next_tag));
      chk("empty",       64'(bus.o_empty),       64'(q.size() == 0));
    end
    model_edge();
    @(posedge clk);
    #1;
    chk("free_valid",   64'(bus.o_free_valid),   64'(exp_fv));
    chk("free_prns",    64'(bus.o_free_prns),    64'(exp_fp));
    chk("retire_count", 64'(bus.o_retire_count), 64'(exp_rc));
  endtask

  task automatic step(input bit a, input logic [MO-1:0] ov,
                      input logic [PB-1:0] p0, input logic [PB-1:0] p1,
                      input logic [PB-1:0] p2, input bit c, input int t);
    v_rst   = 1'b0;
    v_alloc = a;
    v_ov    = ov;
    v_prn   = {p2, p1, p0};
    v_comp  = c;
    v_ctag  = t;
    cycle(1'b1);
  endtask

  task automatic idle();
    step(0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic do_reset();
    v_rst = 1'b1; v_alloc = 1'b0; v_comp = 1'b0;
    cycle(1'b1);
  endtask

  initial begin
    // 1. Reset (state is X before the first edge, so skip comb checks there)
    v_rst = 1'b1;
    cycle(1'b0);
    v_rst = 1'b0; v_alloc = 1'b0; v_comp = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.o_alloc_ready), 64'd1);
    chk("rst_empty", 64'(bus.o_empty), 64'd1);

    // 2. Single entry, slot 1 unused
    step(1, 3'b101, 6'd5, 6'd33, 6'd9, 0, 0);
    step(0, '0, '0, '0, '0, 1, 0);
    idle();
    chk("t2_fv", 64'(bus.o_free_valid), 64'b000101);
    chk("t2_p0", 64'(bus.o_free_prns[0]), 64'd5);
    chk("t2_p2", 64'(bus.o_free_prns[2]), 64'd9);
    chk("t2_rc", 64'(bus.o_retire_count), 64'd1);
    idle();

    // 3. Out-of-order completion, then dual retire
    step(1, 3'b111, 6'd1, 6'd2, 6'd3, 0, 0);
    step(1, 3'b011, 6'd10, 6'd11, 6'd12, 0, 0);
    step(0, '0, '0, '0, '0, 1, 2);
    idle();
    chk("t3_norb", 64'(bus.o_retire_count), 64'd0);
    step(0, '0, '0, '0, '0, 1, 1);
    idle();
    chk("t3_rc2", 64'(bus.o_retire_count), 64'd2);
    chk("t3_p3", 64'(bus.o_free_prns[3]), 64'd10);
    idle();

    // 4. Fill to full, overflow attempt, retire, wrap of alloc_tag
    do_reset();
    for (int i = 0; i < D; i++) step(1, 3'b001, 6'(i + 20), 6'd0, 6'd0, 0, 0);
    step(1, 3'b111, 6'd63, 6'd63, 6'd63, 0, 0);
    chk("t4_full", 64'(bus.o_alloc_ready), 64'd0);
    step(0, '0, '0, '0, '0, 1, 0);
    idle();
    chk("t4_rc", 64'(bus.o_retire_count), 64'd1);
    chk("t4_ready", 64'(bus.o_alloc_ready), 64'd1);
    chk("t4_wrap", 64'(bus.o_alloc_tag), 64'd0);
    step(1, 3'b010, 6'd0, 6'd44, 6'd0, 0, 0);

    // 5. Head at 15, dual retire across the wrap, then stale complete
    do_reset();
    for (int i = 0; i < D - 1; i++) step(1, 3'b100, 6'd0, 6'd0, 6'(i), 1, i - 1);
    step(0, '0, '0, '0, '0, 1, D - 2);
    for (int i = 0; i < 3; i++) idle();
    step(1, 3'b111, 6'd40, 6'd41, 6'd42, 0, 0);
    step(1, 3'b111, 6'd50, 6'd51, 6'd52, 0, 0);
    step(0, '0, '0, '0, '0, 1, 0);
    step(0, '0, '0, '0, '0, 1, 15);
    idle();
    chk("t5_rc2", 64'(bus.o_retire_count), 64'd2);
    step(0, '0, '0, '0, '0, 1, 5);
    idle();
    chk("t5_stale", 64'(bus.o_retire_count), 64'd0);

    // 6. Reset with 5 busy entries, 2 of them done
    for (int i = 0; i < 5; i++) step(1, 3'b111, 6'(i), 6'(i), 6'(i), 0, 0);
    step(0, '0, '0, '0, '0, 1, 4);
    step(0, '0, '0, '0, '0, 1, 5);
    do_reset();
    chk("t6_fv", 64'(bus.o_free_valid), 64'd0);
    idle();
    chk("t6_empty", 64'(bus.o_empty), 64'd1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit a, c;
      int t;
      a = ($urandom_range(0, 99) < 55);
      c = 1'b0;
      t = 0;
      if (q.size() > 0 && $urandom_range(0, 99) < 60) begin
        c = 1'b1;
        t = q[$urandom_range(0, q.size() - 1)].tag;
      end else if ($urandom_range(0, 99) < 15) begin
        c = 1'b1;
        t = $urandom_range(0, D - 1);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(a, 3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), c, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
